small_lpf2nd_mc: RTL and testbench

Multi-channel, time-multiplexed second-order low-pass filter built from two cascaded shift-coefficient leaky integrators. It is the parametrised successor to the single-channel small LPF. It adds:
- per-channel state for up to NUM_CH interleaved streams
- run-time coefficient shifts
- a bypass mode
- a global state clear
- a two-stage pipeline with same-channel forwarding

It sits between a channelised sample source (decimator/mixer bank) and downstream per-channel processing.

---
 rtl/small_lpf2nd_mc.sv | 145 ++++++++++++++
 tb/tb_small_lpf2nd_mc.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/small_lpf2nd_mc.sv
// rtl/small_lpf2nd_mc.sv - multi-channel time-multiplexed second-order leaky-integrator low-pass filter
//
// Two cascaded shift-coefficient leaky integrators with per-channel state.
// Stage S1 captures the sample and reads its channel state; stage S2 computes
// the update, writes the state back and registers the output. The result is
// two-cycle latency at one sample per clock.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   clr       in   synchronous clear of all channel state
//   bypass    in   pass accepted sample through unfiltered, state untouched
//   k0Shift   in   first-stage shift, saturated to MAX_SHIFT
//   k1Shift   in   second-stage shift, saturated to MAX_SHIFT
//   inValid   in   sample strobe (no back-pressure)
//   inChan    in   channel of input sample; >= NUM_CH is dropped
//   dataIn    in   signed input sample
//   outValid  out  one-cycle output strobe
//   outChan   out  channel of output sample
//   dataOut   out  signed filtered sample
module small_lpf2nd_mc #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_SHIFT = 8,
    localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int SW       = $clog2(MAX_SHIFT + 1),
    localparam int ACC_W    = WIDTH + MAX_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    bypass,
    input  logic [SW-1:0]           k0Shift,
    input  logic [SW-1:0]           k1Shift,
    input  logic                    inValid,
    input  logic [CW-1:0]           inChan,
    input  logic signed [WIDTH-1:0] dataIn,
    output logic                    outValid,
    output logic [CW-1:0]           outChan,
    output logic signed [WIDTH-1:0] dataOut
);

    localparam logic [CW:0]   CH_LIM = (CW + 1)'(NUM_CH);
    localparam logic [SW-1:0] K_MAX  = SW'(MAX_SHIFT);

    logic signed [ACC_W-1:0] a0_mem [NUM_CH];
    logic signed [ACC_W-1:0] a1_mem [NUM_CH];

    // S1 registers
    logic                    s1_valid;
    logic [CW-1:0]           s1_chan;
    logic signed [WIDTH-1:0] s1_x;
    logic [SW-1:0]           s1_k0;
    logic [SW-1:0]           s1_k1;
    logic                    s1_byp;
    logic signed [ACC_W-1:0] s1_a0;
    logic signed [ACC_W-1:0] s1_a1;

    // S2 combinational update
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] y0;
    logic signed [ACC_W-1:0] y1;
    logic signed [ACC_W-1:0] a0_nxt;
    logic signed [ACC_W-1:0] a1_nxt;
    logic signed [WIDTH-1:0] y_out;

    logic          accept;
    logic          wb_en;
    logic          fwd;
    logic [SW-1:0] k0_sat;
    logic [SW-1:0] k1_sat;

    assign accept = inValid && ({1'b0, inChan} < CH_LIM);
    assign k0_sat = (k0Shift > K_MAX) ? K_MAX : k0Shift;
    assign k1_sat = (k1Shift > K_MAX) ? K_MAX : k1Shift;

    // Bypassed samples never write state, so they must not be forwarded either.
    assign wb_en = s1_valid && !s1_byp;
    assign fwd   = accept && wb_en && (s1_chan == inChan);

    always_comb begin
        x_ext  = {{MAX_SHIFT{s1_x[WIDTH-1]}}, s1_x};
        y0     = s1_a0 >>> s1_k0;
        y1     = s1_a1 >>> s1_k1;
        a0_nxt = s1_a0 + x_ext - y0;
        a1_nxt = s1_a1 + y0 - y1;
        y_out  = WIDTH'(a1_nxt >>> s1_k1);
    end

    // Channel state: clr wins over the write-back of the sample leaving S1.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                a0_mem[i] <= '0;
                a1_mem[i] <= '0;
            end
        end else if (wb_en) begin
            a0_mem[s1_chan] <= a0_nxt;
            a1_mem[s1_chan] <= a1_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_chan  <= '0;
            s1_x     <= '0;
            s1_k0    <= '0;
            s1_k1    <= '0;
            s1_byp   <= 1'b0;
            s1_a0    <= '0;
            s1_a1    <= '0;
            outValid <= 1'b0;
            outChan  <= '0;
            dataOut  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_chan <= inChan;
                s1_x    <= dataIn;
                s1_k0   <= k0_sat;
                s1_k1   <= k1_sat;
                s1_byp  <= bypass;
                // The array is being written this same edge, so a same-channel
                // read takes the value being written instead of the stale entry.
                if (clr) begin
                    s1_a0 <= '0;
                    s1_a1 <= '0;
                end else if (fwd) begin
                    s1_a0 <= a0_nxt;
                    s1_a1 <= a1_nxt;
                end else begin
                    s1_a0 <= a0_mem[inChan];
                    s1_a1 <= a1_mem[inChan];
                end
            end
            outValid <= s1_valid;
            if (s1_valid) begin
                outChan <= s1_chan;
                dataOut <= s1_byp ? s1_x : y_out;
            end
        end
    end

endmodule

// File: tb/tb_small_lpf2nd_mc.sv
// tb/tb_small_lpf2nd_mc.sv - scoreboard testbench for small_lpf2nd_mc
module tb_small_lpf2nd_mc;

    localparam int NUM_CH    = 5;
    localparam int WIDTH     = 16;
    localparam int MAX_SHIFT = 8;
    localparam int CW        = 3;
    localparam int SW        = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    clr;
    logic                    bypass;
    logic [SW-1:0]           k0Shift;
    logic [SW-1:0]           k1Shift;
    logic                    inValid;
    logic [CW-1:0]           inChan;
    logic signed [WIDTH-1:0] dataIn;
    logic                    outValid;
    logic [CW-1:0]           outChan;
    logic signed [WIDTH-1:0] dataOut;

    small_lpf2nd_mc #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .MAX_SHIFT(MAX_SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bypass(bypass),
        .k0Shift(k0Shift), .k1Shift(k1Shift), .inValid(inValid),
        .inChan(inChan), .dataIn(dataIn), .outValid(outValid),
        .outChan(outChan), .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        int chan;
        int data;
        int cyc;
    } exp_t;

    exp_t   sb[$];
    int     cyc = 0;
    logic   rst_q = 1'b0;
    int     n_checks = 0;
    int     n_fail = 0;
    longint m_a0[NUM_CH];
    longint m_a1[NUM_CH];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    function automatic void model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            m_a0[i] = 0;
            m_a1[i] = 0;
        end
    endfunction

    function automatic int model_step(int ch, int x, int k0, int k1);
        longint y0, y1, n0, n1;
        int s0, s1;
        s0 = (k0 > MAX_SHIFT) ? MAX_SHIFT : k0;
        s1 = (k1 > MAX_SHIFT) ? MAX_SHIFT : k1;
        y0 = m_a0[ch] >>> s0;
        y1 = m_a1[ch] >>> s1;
        n0 = m_a0[ch] + longint'(x) - y0;
        n1 = m_a1[ch] + y0 - y1;
        m_a0[ch] = n0;
        m_a1[ch] = n1;
        return int'(n1 >>> s1);
    endfunction

    // Drive one cycle of stimulus; hand values override the model's expectation.
    task automatic issue(input bit v, input int ch, input int x, input bit byp,
                         input int k0, input int k1, input bit c,
                         input bit use_hand, input int hand);
        int e;
        inValid = v;
        inChan  = CW'(ch);
        dataIn  = WIDTH'(x);
        bypass  = byp;
        k0Shift = SW'(k0);
        k1Shift = SW'(k1);
        clr     = c;
        if (c) model_clear();
        if (v && ch < NUM_CH) begin
            e = byp ? x : model_step(ch, x, k0, k1);
            if (use_hand) e = hand;
            sb.push_back('{chan: ch, data: e, cyc: cyc + 2});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        inValid = 1'b1;
        inChan  = 3'd3;
        dataIn  = 16'sd777;
        clr     = 1'b0;
        bypass  = 1'b0;
        k0Shift = 4'd2;
        k1Shift = 4'd2;
        repeat (3) @(negedge clk);
        model_clear();
        rst_n   = 1'b1;
        inValid = 1'b0;
    endtask

    // Monitor: reset values, scoreboard pops on outValid, hold checks otherwise.
    exp_t                    mon_e;
    logic signed [WIDTH-1:0] last_d = '0;
    logic [CW-1:0]           last_c = '0;
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (!rst_q) begin
                n_checks++;
                if (outValid !== 1'b0 || dataOut !== '0 || outChan !== '0) begin
                    n_fail++;
                    $display("FAIL reset_out: outValid=%b outChan=%0d dataOut=%0d, required 0 0 0",
                             outValid, outChan, dataOut);
                end
                last_d = '0;
                last_c = '0;
            end else if (outValid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: outChan=%0d dataOut=%0d at cycle %0d, required no output",
                             outChan, dataOut, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if ($isunknown({outChan, dataOut}) || int'(outChan) != mon_e.chan ||
                        int'(dataOut) != mon_e.data || cyc != mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL sample_out: chan=%0d data=%0d cycle=%0d, required chan=%0d data=%0d cycle=%0d",
                                 outChan, dataOut, cyc, mon_e.chan, mon_e.data, mon_e.cyc);
                    end
                end
                last_d = dataOut;
                last_c = outChan;
            end else begin
                n_checks++;
                if (outValid !== 1'b0 || dataOut !== last_d || outChan !== last_c) begin
                    n_fail++;
                    $display("FAIL hold_out: outValid=%b outChan=%0d dataOut=%0d, required 0 %0d %0d",
                             outValid, outChan, dataOut, last_c, last_d);
                end
            end
        end
    end

    initial begin
        model_clear();
        // Reset with inValid held high, then two quiet cycles.
        do_reset();
        idle(2);

        // Step on ch0, k0=k1=2, from zero state.
        for (int i = 0; i < 200; i++)
            issue(1'b1, 0, 1000, 1'b0, 2, 2, 1'b0, (i < 2) || (i == 199),
                  (i == 0) ? 0 : (i == 1) ? 62 : 1000);

        // clr during the settled step: in-flight emitted, cleared sample sees zero state.
        issue(1'b1, 0, 1000, 1'b0, 2, 2, 1'b0, 1'b1, 1000);
        issue(1'b1, 0, 1000, 1'b0, 2, 2, 1'b1, 1'b1, 0);
        issue(1'b1, 0, 1000, 1'b0, 2, 2, 1'b0, 1'b1, 62);

        // Negative step from a fresh clear.
        for (int i = 0; i < 200; i++)
            issue(1'b1, 0, -1000, 1'b0, 2, 2, (i == 0), (i < 2) || (i == 199),
                  (i == 0) ? 0 : (i == 1) ? -63 : -1000);

        // Round-robin over four channels, k0=k1=3, each settles to its own input.
        for (int r = 0; r < 250; r++)
            for (int c = 0; c < 4; c++)
                issue(1'b1, c, 1000 * (c + 1), 1'b0, 3, 3, 1'b0, (r == 249), 1000 * (c + 1));

        // Bypass on ch1 leaves its settled state intact.
        for (int i = 0; i < 5; i++)
            issue(1'b1, 1, 1234, 1'b1, 3, 3, 1'b0, 1'b1, 1234);
        issue(1'b1, 1, 2000, 1'b0, 3, 3, 1'b0, 1'b1, 2000);

        // Shift change mid-pipeline and shift saturation, back-to-back on ch4.
        issue(1'b1, 4, 1000, 1'b0, 2, 2, 1'b0, 1'b1, 0);
        issue(1'b1, 4, 1000, 1'b0, 2, 2, 1'b0, 1'b1, 62);
        issue(1'b1, 4, 1000, 1'b0, 7, 2, 1'b0, 1'b1, 50);
        issue(1'b1, 4, 1000, 1'b0, 15, 2, 1'b0, 1'b1, 40);

        // Forwarding: ch2 every cycle, then alternating ch2/ch1 with k0=0.
        for (int i = 0; i < 12; i++)
            issue(1'b1, 2, ((i * 731) % 4000) - 2000, 1'b0, 1, 2, 1'b0, 1'b0, 0);
        for (int i = 0; i < 12; i++)
            issue(1'b1, (i % 2 == 0) ? 2 : 1, ((i * 1237) % 6000) - 3000, 1'b0, 0, 1, 1'b0, 1'b0, 0);

        // Dropped channels interleaved with ch3 traffic.
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 5 + i, 9999, 1'b0, 2, 2, 1'b0, 1'b0, 0);
            issue(1'b1, 3, 500 * i, 1'b0, 2, 2, 1'b0, 1'b0, 0);
        end

        // Mid-run reset with ch3 holding state; afterwards ch3 is back at zero.
        idle(3);
        do_reset();
        idle(2);
        issue(1'b1, 3, 1000, 1'b0, 2, 2, 1'b0, 1'b1, 0);
        issue(1'b1, 3, 1000, 1'b0, 2, 2, 1'b0, 1'b1, 62);

        for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
        idle(2);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d outputs missing, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
